// File: rtl/crc_stream_mc.sv
// Multi-channel streaming CRC engine: valid/ready input, per-channel CRC/length/keep-error
// contexts for interleaved packets, one registered result per packet with optional CRC compare.
module crc_stream_mc #(
    parameter int                   DWIDTH    = 64,
    parameter int                   CRC_WIDTH = 32,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 32'h04C11DB7,
    parameter logic [CRC_WIDTH-1:0] INIT      = 32'hFFFFFFFF,
    parameter logic [CRC_WIDTH-1:0] XOR_OUT   = 32'hFFFFFFFF,
    parameter bit                   REFIN     = 1'b1,
    parameter bit                   REFOUT    = 1'b1,
    parameter int                   NUM_CH    = 4,
    parameter int                   LEN_W     = 16,
    localparam int                  KW        = DWIDTH / 8,
    localparam int                  CHW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DWIDTH-1:0]    s_data,
    input  logic [KW-1:0]        s_keep,
    input  logic                 s_last,
    input  logic [CHW-1:0]       s_chan,
    input  logic [CRC_WIDTH-1:0] s_crc_exp,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [CRC_WIDTH-1:0] m_crc,
    output logic [CHW-1:0]       m_chan,
    output logic [LEN_W-1:0]     m_len,
    output logic                 m_match,
    output logic                 m_keep_err
);

    localparam int SW = LEN_W + $clog2(KW + 1);

    logic [CRC_WIDTH-1:0] ctx_crc [NUM_CH];
    logic [LEN_W-1:0]     ctx_len [NUM_CH];
    logic [NUM_CH-1:0]    ctx_kerr;

    logic                 accept;
    logic                 chan_ok;
    logic [CRC_WIDTH-1:0] cur_crc;
    logic [LEN_W-1:0]     cur_len;
    logic                 cur_kerr;
    logic [CRC_WIDTH-1:0] nxt_crc;
    logic [CRC_WIDTH-1:0] rev_crc;
    logic [CRC_WIDTH-1:0] fin_crc;
    logic [SW-1:0]        len_sum;
    logic [LEN_W-1:0]     nxt_len;
    logic [KW-1:0]        keep_p1;
    logic                 beat_err;
    logic                 nxt_kerr;
    logic                 bit_in;
    logic                 fb;

    assign s_ready = !m_valid || m_ready;
    assign accept  = s_valid && s_ready;

    // Context read mux; an out-of-range channel matches nothing and leaves chan_ok low.
    always_comb begin
        cur_crc  = INIT;
        cur_len  = '0;
        cur_kerr = 1'b0;
        chan_ok  = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (s_chan == CHW'(c)) begin
                cur_crc  = ctx_crc[c];
                cur_len  = ctx_len[c];
                cur_kerr = ctx_kerr[c];
                chan_ok  = 1'b1;
            end
        end
    end

    // Bit-serial CRC over enabled bytes only; disabled bytes are skipped entirely.
    always_comb begin
        nxt_crc = cur_crc;
        bit_in  = 1'b0;
        fb      = 1'b0;
        for (int i = 0; i < KW; i++) begin
            if (s_keep[i]) begin
                for (int j = 0; j < 8; j++) begin
                    bit_in  = REFIN ? s_data[8*i + j] : s_data[8*i + 7 - j];
                    fb      = nxt_crc[CRC_WIDTH-1] ^ bit_in;
                    nxt_crc = {nxt_crc[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
                end
            end
        end
    end

    always_comb begin
        rev_crc = '0;
        for (int i = 0; i < CRC_WIDTH; i++) begin
            rev_crc[i] = nxt_crc[CRC_WIDTH-1-i];
        end
        fin_crc = (REFOUT ? rev_crc : nxt_crc) ^ XOR_OUT;
    end

    always_comb begin
        len_sum = SW'(cur_len);
        for (int i = 0; i < KW; i++) begin
            if (s_keep[i]) begin
                len_sum = len_sum + SW'(1);
            end
        end
        if (len_sum > SW'({LEN_W{1'b1}})) begin
            nxt_len = '1;
        end else begin
            nxt_len = len_sum[LEN_W-1:0];
        end
    end

    // Last beat must be a non-empty run of ones from byte 0; keep & (keep+1) is zero only then.
    always_comb begin
        keep_p1 = s_keep + KW'(1);
        if (s_last) begin
            beat_err = (s_keep == '0) || ((s_keep & keep_p1) != '0);
        end else begin
            beat_err = (s_keep != '1);
        end
        nxt_kerr = cur_kerr | beat_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ctx_crc[c]  <= INIT;
                ctx_len[c]  <= '0;
                ctx_kerr[c] <= 1'b0;
            end
        end else if (accept) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (s_chan == CHW'(c)) begin
                    if (s_last) begin
                        ctx_crc[c]  <= INIT;
                        ctx_len[c]  <= '0;
                        ctx_kerr[c] <= 1'b0;
                    end else begin
                        ctx_crc[c]  <= nxt_crc;
                        ctx_len[c]  <= nxt_len;
                        ctx_kerr[c] <= nxt_kerr;
                    end
                end
            end
        end
    end

    // Single output register; a new result may load on the same edge the old one retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid    <= 1'b0;
            m_crc      <= '0;
            m_chan     <= '0;
            m_len      <= '0;
            m_match    <= 1'b0;
            m_keep_err <= 1'b0;
        end else if (accept && s_last && chan_ok) begin
            m_valid    <= 1'b1;
            m_crc      <= fin_crc;
            m_chan     <= s_chan;
            m_len      <= nxt_len;
            m_match    <= (fin_crc == s_crc_exp);
            m_keep_err <= nxt_kerr;
        end else if (m_ready) begin
            m_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_crc_stream_mc.sv
// Directed bench for crc_stream_mc: default CRC-32 instance plus a CRC-16/CCITT-FALSE
// instance with 3 channels and a 4-bit length counter.
module tb_crc_stream_mc;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_s_valid, a_s_ready, a_s_last, a_m_valid, a_m_ready, a_m_match, a_m_keep_err;
    logic [63:0] a_s_data;
    logic [7:0]  a_s_keep;
    logic [1:0]  a_s_chan, a_m_chan;
    logic [31:0] a_s_crc_exp, a_m_crc;
    logic [15:0] a_m_len;

    logic        b_s_valid, b_s_ready, b_s_last, b_m_valid, b_m_ready, b_m_match, b_m_keep_err;
    logic [15:0] b_s_data;
    logic [1:0]  b_s_keep;
    logic [1:0]  b_s_chan, b_m_chan;
    logic [15:0] b_s_crc_exp, b_m_crc;
    logic [3:0]  b_m_len;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    crc_stream_mc u_a (
        .clk(clk), .rst(rst),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data), .s_keep(a_s_keep),
        .s_last(a_s_last), .s_chan(a_s_chan), .s_crc_exp(a_s_crc_exp),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_crc(a_m_crc), .m_chan(a_m_chan),
        .m_len(a_m_len), .m_match(a_m_match), .m_keep_err(a_m_keep_err)
    );

    crc_stream_mc #(
        .DWIDTH(16), .CRC_WIDTH(16), .CRC_POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000),
        .REFIN(1'b0), .REFOUT(1'b0), .NUM_CH(3), .LEN_W(4)
    ) u_b (
        .clk(clk), .rst(rst),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data), .s_keep(b_s_keep),
        .s_last(b_s_last), .s_chan(b_s_chan), .s_crc_exp(b_s_crc_exp),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_crc(b_m_crc), .m_chan(b_m_chan),
        .m_len(b_m_len), .m_match(b_m_match), .m_keep_err(b_m_keep_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic a_beat(input int ch, input logic [63:0] d, input logic [7:0] k,
                          input logic l, input logic [31:0] e);
        a_s_chan = 2'(ch); a_s_data = d; a_s_keep = k; a_s_last = l; a_s_crc_exp = e;
        a_s_valid = 1'b1;
        step(1);
        a_s_valid = 1'b0; a_s_last = 1'b0;
    endtask

    task automatic b_beat(input int ch, input logic [15:0] d, input logic [1:0] k,
                          input logic l, input logic [15:0] e);
        b_s_chan = 2'(ch); b_s_data = d; b_s_keep = k; b_s_last = l; b_s_crc_exp = e;
        b_s_valid = 1'b1;
        step(1);
        b_s_valid = 1'b0; b_s_last = 1'b0;
    endtask

    localparam logic [63:0] A18 = 64'h3837363534333231;  // "12345678"
    localparam logic [31:0] C32 = 32'hCBF43926;

    initial begin
        rst = 1'b1;
        a_s_valid = 0; a_s_data = 0; a_s_keep = 0; a_s_last = 0; a_s_chan = 0; a_s_crc_exp = 0;
        b_s_valid = 0; b_s_data = 0; b_s_keep = 0; b_s_last = 0; b_s_chan = 0; b_s_crc_exp = 0;
        a_m_ready = 1'b1; b_m_ready = 1'b1;
        #3;
        chk("rst_m_valid", a_m_valid, 0);
        chk("rst_m_crc", a_m_crc, 0);
        chk("rst_m_len", a_m_len, 0);
        chk("rst_m_match", a_m_match, 0);
        chk("rst_m_keep_err", a_m_keep_err, 0);
        chk("rst_s_ready", a_s_ready, 1);
        #9 rst = 1'b0;
        step(1);

        // Basic CRC-32 "123456789" on ch 0
        a_beat(0, A18, 8'hFF, 0, 0);
        a_beat(0, 64'h39, 8'h01, 1, C32);
        chk("basic_valid", a_m_valid, 1);
        chk("basic_crc", a_m_crc, C32);
        chk("basic_len", a_m_len, 9);
        chk("basic_match", a_m_match, 1);
        chk("basic_kerr", a_m_keep_err, 0);
        chk("basic_chan", a_m_chan, 0);
        step(1);
        chk("basic_retire", a_m_valid, 0);

        // CRC-16/CCITT-FALSE, MSB-first, 2-byte beats
        b_beat(0, 16'h3231, 2'b11, 0, 0);
        b_beat(0, 16'h3433, 2'b11, 0, 0);
        b_beat(0, 16'h3635, 2'b11, 0, 0);
        b_beat(0, 16'h3837, 2'b11, 0, 0);
        b_beat(0, 16'h0039, 2'b01, 1, 16'h29B1);
        chk("c16_valid", b_m_valid, 1);
        chk("c16_crc", b_m_crc, 16'h29B1);
        chk("c16_len", b_m_len, 9);
        chk("c16_match", b_m_match, 1);
        step(1);

        // Interleaved channels 1 and 2; ch 2 given a wrong expected value
        a_beat(1, A18, 8'hFF, 0, 0);
        a_beat(2, A18, 8'hFF, 0, 0);
        a_beat(1, 64'h39, 8'h01, 1, C32);
        chk("il1_valid", a_m_valid, 1);
        chk("il1_chan", a_m_chan, 1);
        chk("il1_crc", a_m_crc, C32);
        a_beat(2, 64'h39, 8'h01, 1, 32'h12345678);
        chk("il2_valid", a_m_valid, 1);
        chk("il2_chan", a_m_chan, 2);
        chk("il2_crc", a_m_crc, C32);
        chk("il2_len", a_m_len, 9);
        chk("il2_match", a_m_match, 0);
        step(1);
        chk("il_retire", a_m_valid, 0);

        // Backpressure: result on ch 0 held while ch 3's last beat waits
        a_m_ready = 1'b0;
        a_beat(3, A18, 8'hFF, 0, 0);
        a_beat(0, A18, 8'hFF, 0, 0);
        a_beat(0, 64'h39, 8'h01, 1, C32);
        a_s_chan = 2'd3; a_s_data = 64'h39; a_s_keep = 8'h01; a_s_last = 1'b1; a_s_crc_exp = C32;
        a_s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_s_ready", a_s_ready, 0);
            chk("bp_m_valid", a_m_valid, 1);
            chk("bp_m_chan", a_m_chan, 0);
            chk("bp_m_crc", a_m_crc, C32);
            step(1);
        end
        a_m_ready = 1'b1;
        #1;
        chk("bp_s_ready_up", a_s_ready, 1);
        step(1);
        a_s_valid = 1'b0; a_s_last = 1'b0;
        chk("b2b_valid", a_m_valid, 1);
        chk("b2b_chan", a_m_chan, 3);
        chk("b2b_crc", a_m_crc, C32);
        chk("b2b_len", a_m_len, 9);
        step(1);
        chk("b2b_retire", a_m_valid, 0);

        // Keep violation on a non-last beat; disabled bytes carry junk
        a_beat(1, 64'hAAAAAAAA34333231, 8'h0F, 0, 0);
        a_beat(1, 64'hBBBBBB3938373635, 8'h1F, 1, C32);
        chk("kerr_flag", a_m_keep_err, 1);
        chk("kerr_crc", a_m_crc, C32);
        chk("kerr_len", a_m_len, 9);
        a_beat(1, A18, 8'hFF, 0, 0);
        a_beat(1, 64'h39, 8'h01, 1, C32);
        chk("kerr_clear", a_m_keep_err, 0);
        chk("kerr_clear_crc", a_m_crc, C32);

        // Non-contiguous last keep: only byte 1 enabled
        a_beat(2, A18, 8'hFF, 0, 0);
        a_beat(2, 64'h3900, 8'h02, 1, C32);
        chk("lastkeep_flag", a_m_keep_err, 1);
        chk("lastkeep_crc", a_m_crc, C32);
        step(1);

        // Length saturation on the 4-bit counter: 17 bytes -> 15
        for (int i = 0; i < 8; i++) b_beat(1, 16'h3231, 2'b11, 0, 0);
        b_beat(1, 16'h0039, 2'b01, 1, 0);
        chk("sat_len", b_m_len, 4'hF);
        chk("sat_kerr", b_m_keep_err, 0);
        step(1);

        // Out-of-range channel 3 interleaved into a ch 2 packet
        b_beat(2, 16'h3231, 2'b11, 0, 0);
        b_s_chan = 2'd3;
        #1;
        chk("oor_s_ready", b_s_ready, 1);
        b_beat(3, 16'h3433, 2'b11, 0, 0);
        b_beat(3, 16'h0039, 2'b01, 1, 0);
        chk("oor_no_result", b_m_valid, 0);
        b_beat(2, 16'h3433, 2'b11, 0, 0);
        b_beat(2, 16'h3635, 2'b11, 0, 0);
        b_beat(2, 16'h3837, 2'b11, 0, 0);
        b_beat(2, 16'h0039, 2'b01, 1, 0);
        chk("oor_ch2_crc", b_m_crc, 16'h29B1);
        chk("oor_ch2_chan", b_m_chan, 2);
        step(1);

        // Async reset with a pending result and a partial ch 0 packet
        a_m_ready = 1'b0;
        a_beat(0, A18, 8'hFF, 0, 0);
        a_beat(1, A18, 8'hFF, 0, 0);
        a_beat(1, 64'h39, 8'h01, 1, C32);
        chk("pre_rst_valid", a_m_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", a_m_valid, 0);
        chk("async_rst_crc", a_m_crc, 0);
        #1 rst = 1'b0;
        a_m_ready = 1'b1;
        a_beat(0, A18, 8'hFF, 0, 0);
        a_beat(0, 64'h39, 8'h01, 1, C32);
        chk("replay_crc", a_m_crc, C32);
        chk("replay_len", a_m_len, 9);
        chk("replay_kerr", a_m_keep_err, 0);
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/crc_stream_mc.md
Name: crc_stream_mc

Overview:
- Multi-channel, streaming CRC engine; successor to the single-stream byte-enable CRC generator.
- Adds valid/ready handshake with backpressure, NUM_CH independent per-channel CRC contexts (interleaved packets), a per-packet byte count, and an optional compare-against-expected check.
- Sits between a packet framer/deframer and the MAC-side logic; one beat per cycle at full throughput.

Parameters:
- DWIDTH, 64, data width in bits; multiple of 8, >= 16.
- CRC_WIDTH, 32, CRC width, 8..64.
- CRC_POLY, 32'h04C11DB7, generator polynomial, normal form, implicit top bit.
- INIT, 32'hFFFFFFFF, register value at packet start.
- XOR_OUT, 32'hFFFFFFFF, final XOR.
- REFIN, 1, 1 = bits of each byte processed LSB first.
- REFOUT, 1, 1 = bit-reverse the final register before XOR_OUT.
- NUM_CH, 4, number of independent contexts, >= 1.
- LEN_W, 16, packet byte counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous assert, active-high
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid & s_ready
- s_data  in  DWIDTH  beat data; byte i = s_data[8i+7:8i], byte 0 first on the wire
- s_keep  in  DWIDTH/8  byte enables
- s_last  in  1  last beat of packet
- s_chan  in  max(1,$clog2(NUM_CH))  context select
- s_crc_exp  in  CRC_WIDTH  expected CRC, sampled with the last beat
- m_valid  out  1  result valid
- m_ready  in  1  result consumed when m_valid & m_ready
- m_crc  out  CRC_WIDTH  final CRC: after REFOUT and XOR_OUT
- m_chan  out  same as s_chan  channel of the result
- m_len  out  LEN_W  packet byte count; saturates at all-ones
- m_match  out  1  m_crc == s_crc_exp captured at the last beat
- m_keep_err  out  1  keep-rule violation seen anywhere in the packet

Behaviour:
- Reset (async):
  - all contexts: crc = INIT, len = 0, keep_err = 0.
  - m_valid = 0; m_crc, m_chan, m_len, m_match, m_keep_err = 0.
  - Reset mid-packet discards all partial packets.
- Handshake:
  - s_ready = !m_valid | m_ready (single output register, no skid).
  - s_ready does not depend on s_valid.
  - m_* hold stable while m_valid & !m_ready.
- CRC update per accepted beat:
  - Read context[s_chan] combinationally.
  - Process enabled bytes in order 0..DWIDTH/8-1; disabled bytes are skipped, not zero-padded.
  - Per bit b: fb = crc[CRC_WIDTH-1] ^ b; crc = (crc << 1) ^ (fb ? CRC_POLY : 0).
  - Within a byte, bit order is LSB first if REFIN, MSB first otherwise.
- Context write on an accepted beat:
  - Non-last beat: context[s_chan].crc = updated value; len += popcount(s_keep), saturating; keep_err |= rule violation.
  - Last beat: context restored to INIT / 0 / 0 on the same edge.
  - Back-to-back beats to the same channel use the freshly written value; no stall.
- Keep rules:
  - Non-last beat must have s_keep all ones.
  - Last beat must be contiguous from byte 0 and non-zero.
  - A violating beat is still processed using the enabled bytes as given; the violation only sets keep_err.
- Result:
  - Accepted last beat -> next edge: m_valid = 1 (latency 1 cycle).
  - m_crc = (REFOUT ? bitrev(crc) : crc) ^ XOR_OUT.
  - m_chan = s_chan; m_len = final count; m_match = (m_crc == s_crc_exp); m_keep_err = accumulated flag including the last beat.
- Simultaneous events: on an edge where m_ready and a new last beat arrive together, the old result retires and the new one loads; m_valid stays 1.
- Out-of-range s_chan (>= NUM_CH, non-power-of-2 NUM_CH): beat accepted, no context updated, no result produced.
- Throughput: one beat per cycle while m_ready = 1 or no result is pending.

Test Plan:
- Default params, ch 0, one beat "12345678" keep=FF last=0, then "9" keep=01 last=1, s_crc_exp=CBF43926 -> one cycle later m_valid=1, m_crc=32'hCBF43926, m_len=9, m_match=1, m_keep_err=0.
- CRC_WIDTH=16, POLY=1021, INIT=FFFF, XOR_OUT=0, REFIN=REFOUT=0, DWIDTH=16, "123456789" over 5 beats (last keep=01) -> m_crc=16'h29B1, m_len=9.
- Interleave ch 1 and ch 2 beat-by-beat with the same "123456789" stream -> two results, each 32'hCBF43926, correct m_chan, in last-beat order.
- Hold m_ready=0 after a result, with s_valid=1 -> s_ready=0, m_* stable for 10 cycles; raise m_ready together with a new last beat -> back-to-back results, none lost.
- Non-last beat keep=0F, then a correct last beat -> m_keep_err=1, m_crc computed over the enabled bytes only; next packet on that channel has m_keep_err=0.
- Assert rst mid-packet on ch 0, then replay the full packet -> m_valid drops asynchronously; replay yields 32'hCBF43926, m_len=9.
